unit_pairswap_n: RTL and testbench

- Parametrised successor of the fixed 3-lane perceptron unit.
- W-bit forward/backward lanes are grouped into W/2 lane pairs. Each pair has one learned control bit: 1 = swap the pair, 0 = pass it through.
- Each control bit has its own saturating signed vote accumulator. The bit toggles when its accumulated flip votes reach THRESH.
- Adds a seed-load port, a learning enable, output valid strobes and flip pulses. Sits as one cell in the layered bitnet array.

---
 rtl/unit_pkg.sv | 26 ++
 rtl/grad_accum_sat.sv | 67 ++++++
 rtl/unit_pairswap_n.sv | 161 ++++++++++++++++
 tb/tb_unit_pairswap_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unit_pkg.sv
// Shared types and helpers for the pair-swap learning cell: vote encoding,
// per-pair vote decode and the flip-counter width.
package unit_pkg;

    typedef enum logic [1:0] {
        VOTE_NONE = 2'd0,
        VOTE_KEEP = 2'd1,
        VOTE_FLIP = 2'd2
    } vote_t;

    localparam int FLIP_CNT_W = 16;

    // A pair votes only when its forward lanes differ; the error lanes decide flip vs keep.
    function automatic vote_t pair_vote(input logic fd, input logic bd);
        vote_t v;
        if (fd && bd) begin
            v = VOTE_FLIP;
        end else if (fd) begin
            v = VOTE_KEEP;
        end else begin
            v = VOTE_NONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/grad_accum_sat.sv
// Saturating signed vote accumulator for one control bit; raises trigger when a
// FLIP vote would carry the count to THRESH, and self-clears in that case.
module grad_accum_sat
    import unit_pkg::*;
#(
    parameter int ACC_W  = 4,
    parameter int THRESH = 3
) (
    input  logic  clk_in,
    input  logic  rst_n_in,
    input  logic  clr,
    input  logic  en,
    input  vote_t vote,
    output logic  trigger
);

    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ACC_TRIG = ACC_W'(THRESH - 1);

    if (THRESH < 1 || THRESH > (1 << (ACC_W - 1)) - 1) begin : g_thresh_chk
        $error("grad_accum_sat: THRESH outside 1 .. 2^(ACC_W-1)-1");
    end

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;

    // Next accumulator value and threshold detection
    always_comb begin
        w_acc_nxt = r_acc;
        trigger   = 1'b0;
        if (clr) begin
            w_acc_nxt = '0;
        end else if (en) begin
            case (vote)
                VOTE_FLIP: begin
                    if (r_acc >= ACC_TRIG) begin
                        w_acc_nxt = '0;
                        trigger   = 1'b1;
                    end else begin
                        w_acc_nxt = r_acc + ACC_ONE;
                    end
                end
                VOTE_KEEP: begin
                    if (r_acc != ACC_MIN) begin
                        w_acc_nxt = r_acc - ACC_ONE;
                    end else begin
                        w_acc_nxt = r_acc;
                    end
                end
                default: w_acc_nxt = r_acc;
            endcase
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Accumulator register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/unit_pairswap_n.sv
// Learned pair-swap cell: W lanes in W/2 pairs, each swapped or passed by a
// vote-trained control bit. Define UNIT_FLIP_COUNT_EN to add flip_count_out.
module unit_pairswap_n
    import unit_pkg::*;
#(
    parameter int               W         = 6,
    parameter int               ACC_W     = 4,
    parameter int               THRESH    = 3,
    parameter logic [W/2-1:0]   INIT_CTRL = '0
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               fd_prop,
    input  logic               bk_prop,
    input  logic               learn_en,
    input  logic               seed_valid,
    input  logic [W/2-1:0]     seed_in,
    input  logic [W-1:0]       fin,
    input  logic [W-1:0]       bin,
    output logic [W/2-1:0]     control_out,
    output logic [W-1:0]       fout,
    output logic               fout_valid,
    output logic [W-1:0]       bout,
    output logic               bout_valid,
`ifdef UNIT_FLIP_COUNT_EN
    output logic [FLIP_CNT_W-1:0] flip_count_out,
`endif
    output logic [W/2-1:0]     flip_out
);

    localparam int NCTRL = W / 2;

    if ((W % 2) != 0 || W < 2) begin : g_width_chk
        $error("unit_pairswap_n: W must be even and >= 2");
    end

    logic [NCTRL-1:0] r_ctrl;
    logic [NCTRL-1:0] r_flip;
    logic [NCTRL-1:0] w_trig;
    logic [W-1:0]     w_new_fout;
    logic [W-1:0]     w_new_bout;
    logic [W-1:0]     r_fout;
    logic [W-1:0]     r_bout;
    logic             r_fout_valid;
    logic             r_bout_valid;
    logic             w_learn;

    assign w_learn = bk_prop & learn_en;

    // Lane gate on the pre-update control, shared by both directions
    always_comb begin
        w_new_fout = fin;
        w_new_bout = bin;
        for (int i = 0; i < NCTRL; i++) begin
            if (r_ctrl[i]) begin
                w_new_fout[2*i]   = fin[2*i+1];
                w_new_fout[2*i+1] = fin[2*i];
                w_new_bout[2*i]   = bin[2*i+1];
                w_new_bout[2*i+1] = bin[2*i];
            end else begin
                w_new_fout[2*i]   = fin[2*i];
                w_new_fout[2*i+1] = fin[2*i+1];
                w_new_bout[2*i]   = bin[2*i];
                w_new_bout[2*i+1] = bin[2*i+1];
            end
        end
    end

    for (genvar g = 0; g < NCTRL; g++) begin : g_pair
        vote_t w_vote;
        assign w_vote = pair_vote(fin[2*g] ^ fin[2*g+1], bin[2*g] ^ bin[2*g+1]);

        grad_accum_sat #(
            .ACC_W  (ACC_W),
            .THRESH (THRESH)
        ) u_acc (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .clr      (seed_valid),
            .en       (w_learn),
            .vote     (w_vote),
            .trigger  (w_trig[g])
        );
    end

    // Forward and backward output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_fout       <= '0;
            r_fout_valid <= 1'b0;
            r_bout       <= '0;
            r_bout_valid <= 1'b0;
        end else begin
            if (fd_prop) begin
                r_fout       <= w_new_fout;
                r_fout_valid <= 1'b1;
            end else begin
                r_fout_valid <= 1'b0;
            end
            if (bk_prop) begin
                r_bout       <= w_new_bout;
                r_bout_valid <= 1'b1;
            end else begin
                r_bout_valid <= 1'b0;
            end
        end
    end

    // Control register; a seed load overrides any same-cycle toggle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ctrl <= INIT_CTRL;
            r_flip <= '0;
        end else if (seed_valid) begin
            r_ctrl <= seed_in;
            r_flip <= '0;
        end else begin
            r_ctrl <= r_ctrl ^ w_trig;
            r_flip <= w_trig;
        end
    end

`ifdef UNIT_FLIP_COUNT_EN
    logic [FLIP_CNT_W-1:0] r_flip_cnt;
    logic [FLIP_CNT_W:0]   w_cnt_sum;

    function automatic logic [FLIP_CNT_W-1:0] popcount(input logic [NCTRL-1:0] v);
        logic [FLIP_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NCTRL; i++) begin
            c = c + {{(FLIP_CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_cnt_sum = {1'b0, r_flip_cnt} + {1'b0, popcount(r_flip)};

    // Saturating total-toggle counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_flip_cnt <= '0;
        end else if (seed_valid) begin
            r_flip_cnt <= '0;
        end else if (w_cnt_sum[FLIP_CNT_W]) begin
            r_flip_cnt <= '1;
        end else begin
            r_flip_cnt <= w_cnt_sum[FLIP_CNT_W-1:0];
        end
    end

    assign flip_count_out = r_flip_cnt;
`endif

    assign control_out = r_ctrl;
    assign fout        = r_fout;
    assign fout_valid  = r_fout_valid;
    assign bout        = r_bout;
    assign bout_valid  = r_bout_valid;
    assign flip_out    = r_flip;

endmodule

// File: tb/tb_unit_pairswap_n.sv
// Scoreboard bench for unit_pairswap_n (W=6, ACC_W=4, THRESH=3, INIT_CTRL=0);
// expected fout/bout words are queued at issue and popped by a negedge monitor.
module tb_unit_pairswap_n;

    logic       clk_in     = 1'b0;
    logic       rst_n_in   = 1'b0;
    logic       fd_prop    = 1'b0;
    logic       bk_prop    = 1'b0;
    logic       learn_en   = 1'b0;
    logic       seed_valid = 1'b0;
    logic [2:0] seed_in    = 3'b000;
    logic [5:0] fin        = 6'b000000;
    logic [5:0] bin        = 6'b000000;
    logic [2:0] control_out;
    logic [5:0] fout;
    logic       fout_valid;
    logic [5:0] bout;
    logic       bout_valid;
    logic [2:0] flip_out;
`ifdef UNIT_FLIP_COUNT_EN
    logic [15:0] flip_count_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [5:0] q_f[$];
    logic [5:0] q_b[$];

    unit_pairswap_n #(
        .W(6), .ACC_W(4), .THRESH(3), .INIT_CTRL(3'b000)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .fd_prop     (fd_prop),
        .bk_prop     (bk_prop),
        .learn_en    (learn_en),
        .seed_valid  (seed_valid),
        .seed_in     (seed_in),
        .fin         (fin),
        .bin         (bin),
        .control_out (control_out),
        .fout        (fout),
        .fout_valid  (fout_valid),
        .bout        (bout),
        .bout_valid  (bout_valid),
`ifdef UNIT_FLIP_COUNT_EN
        .flip_count_out (flip_count_out),
`endif
        .flip_out    (flip_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One backward-propagate cycle with its expected bout queued
    task automatic bk(input logic [5:0] f, input logic [5:0] b, input logic [5:0] expb);
        fin = f;
        bin = b;
        bk_prop = 1'b1;
        q_b.push_back(expb);
        tick();
        bk_prop = 1'b0;
    endtask

    task automatic chk_cf(input string nm, input logic [2:0] ctrl, input logic [2:0] flp);
        chk({nm, "_ctrl"}, 32'(control_out), 32'(ctrl));
        chk({nm, "_flip"}, 32'(flip_out), 32'(flp));
    endtask

    // Monitor: every valid output is matched against the scoreboard head
    always @(negedge clk_in) begin
        if (fout_valid) begin
            total++;
            if (q_f.size() == 0) begin
                bad++;
                $display("FAIL fout_unexpected act=%b exp=none", fout);
            end else begin
                logic [5:0] e;
                e = q_f.pop_front();
                if (fout !== e) begin
                    bad++;
                    $display("FAIL fout act=%b exp=%b", fout, e);
                end
            end
        end
        if (bout_valid) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL bout_unexpected act=%b exp=none", bout);
            end else begin
                logic [5:0] e;
                e = q_b.pop_front();
                if (bout !== e) begin
                    bad++;
                    $display("FAIL bout act=%b exp=%b", bout, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_fout", 32'(fout), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_fvalid", 32'(fout_valid), 32'd0);
        chk("rst_bvalid", 32'(bout_valid), 32'd0);
        chk_cf("rst", 3'b000, 3'b000);
        rst_n_in = 1'b1;
        tick();

        // Pass-through forward, one-cycle valid
        fin = 6'b000001;
        fd_prop = 1'b1;
        q_f.push_back(6'b000001);
        tick();
        fd_prop = 1'b0;
        tick();
        chk("fvalid_drop", 32'(fout_valid), 32'd0);
        chk("fout_hold", 32'(fout), 32'(6'b000001));

        // Seeded swap of pair 0
        seed_in = 3'b001;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        chk("seed_ctrl", 32'(control_out), 32'(3'b001));
        fd_prop = 1'b1;
        q_f.push_back(6'b000010);
        tick();
        fd_prop = 1'b0;

        // Three FLIP votes toggle pair 0
        seed_in = 3'b000;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        learn_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bk(6'b000001, 6'b000001, 6'b000001);
            chk_cf("flip3", (i == 2) ? 3'b001 : 3'b000, (i == 2) ? 3'b001 : 3'b000);
        end
        tick();
        chk_cf("flip3_after", 3'b001, 3'b000);

        // KEEP, KEEP, FLIP x4: acc -1,-2,-1,0,1,2 with no toggle
        for (int i = 0; i < 2; i++) begin
            bk(6'b000001, 6'b000000, 6'b000000);
            chk_cf("keep", 3'b001, 3'b000);
        end
        for (int i = 0; i < 4; i++) begin
            bk(6'b000001, 6'b000001, 6'b000010);
            chk_cf("mixflip", 3'b001, 3'b000);
        end

        // Twelve KEEPs saturate at -8, then ten FLIPs reach 2 and the 11th toggles
        for (int i = 0; i < 12; i++) begin
            bk(6'b000001, 6'b000000, 6'b000000);
            chk_cf("sat_keep", 3'b001, 3'b000);
        end
        for (int i = 0; i < 11; i++) begin
            bk(6'b000001, 6'b000001, 6'b000010);
            chk_cf("sat_flip", (i == 10) ? 3'b000 : 3'b001, (i == 10) ? 3'b001 : 3'b000);
        end

        // learn_en low: bout moves, control and accumulator hold
        learn_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bk(6'b000001, 6'b000001, 6'b000001);
            chk_cf("nolearn", 3'b000, 3'b000);
        end
        learn_en = 1'b1;

        // Seed collides with a threshold-reaching FLIP
        for (int i = 0; i < 2; i++) begin
            bk(6'b000001, 6'b000001, 6'b000001);
            chk_cf("pre_seed", 3'b000, 3'b000);
        end
        seed_in = 3'b110;
        seed_valid = 1'b1;
        bk(6'b000001, 6'b000001, 6'b000001);
        seed_valid = 1'b0;
        chk_cf("seed_wins", 3'b110, 3'b000);
        for (int i = 0; i < 3; i++) begin
            bk(6'b000001, 6'b000001, 6'b000001);
            chk_cf("post_seed", (i == 2) ? 3'b111 : 3'b110, (i == 2) ? 3'b001 : 3'b000);
        end

        // Two pairs flip together, forward running on the same cycles
        seed_in = 3'b000;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        fd_prop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q_f.push_back(6'b000101);
            bk(6'b000101, 6'b000101, 6'b000101);
            chk_cf("pair2", (i == 2) ? 3'b011 : 3'b000, (i == 2) ? 3'b011 : 3'b000);
        end
        fd_prop = 1'b0;
        tick();
        chk_cf("pair2_after", 3'b011, 3'b000);
`ifdef UNIT_FLIP_COUNT_EN
        chk("flip_count_2", 32'(flip_count_out), 32'd2);
`endif

        // Asynchronous reset mid-stream with strobes high
        fin = 6'b000101;
        bin = 6'b000101;
        fd_prop = 1'b1;
        bk_prop = 1'b1;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("mrst_fout", 32'(fout), 32'd0);
        chk("mrst_bout", 32'(bout), 32'd0);
        chk("mrst_fvalid", 32'(fout_valid), 32'd0);
        chk("mrst_bvalid", 32'(bout_valid), 32'd0);
        chk_cf("mrst", 3'b000, 3'b000);
`ifdef UNIT_FLIP_COUNT_EN
        chk("mrst_count", 32'(flip_count_out), 32'd0);
`endif
        tick();
        fd_prop = 1'b0;
        bk_prop = 1'b0;
        rst_n_in = 1'b1;
        tick();

        // Forward path alive after reset with INIT_CTRL
        fin = 6'b000010;
        fd_prop = 1'b1;
        q_f.push_back(6'b000010);
        tick();
        fd_prop = 1'b0;
        tick();

        chk("q_f_drained", 32'(q_f.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
